// File: rtl/gate_pkg.sv
// gate_pkg: op encodings, state encoding and op sequencing shared by the gate scan unit
package gate_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_LAST = OP_XNOR;
  typedef enum logic [1:0] {S_IDLE, S_MAN, S_SCAN} state_e;
  function automatic logic [2:0] op_next(input logic [2:0] op);
    return op == OP_LAST ? OP_AND : op + 3'd1;
  endfunction
endpackage

// File: rtl/gate_bitwise_core.sv
// gate_bitwise_core: combinational two-operand gate; illegal encodings yield zero
module gate_bitwise_core
  import gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);
  assign y = op == OP_AND  ? a & b :
             op == OP_NAND ? ~(a & b) :
             op == OP_OR   ? a | b :
             op == OP_NOR  ? ~(a | b) :
             op == OP_XOR  ? a ^ b :
             op == OP_XNOR ? ~(a ^ b) : '0;
  assign illegal = op > OP_LAST;
endmodule

// File: rtl/gate_scan_unit.sv
// gate_scan_unit: registered gate unit with manual and timed scan modes; GATE_PARITY_EN adds a Parity output
module gate_scan_unit
  import gate_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  input  logic [2:0]       Op_Sel,
  input  logic             Mode,
  input  logic             In_Valid,
  output logic [WIDTH-1:0] Result,
  output logic             Out_Valid,
  output logic [2:0]       Op_Cur,
  output logic             Op_Err
`ifdef GATE_PARITY_EN
  ,
  output logic             Parity
`endif
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, a_use, b_use, y;
  logic [2:0] idx_q, idx_d, opc_q, opc_d, idx_nx, core_op;
  logic [DW-1:0] div_q, div_d;
  logic vld_q, vld_d, err_q, err_d, illegal, term;
  // A capture on this edge feeds the result directly, so operands bypass the holding registers
  assign a_use = In_Valid ? A_In : a_q;
  assign b_use = In_Valid ? B_In : b_q;
  assign idx_nx = op_next(idx_q);
  assign term = div_q == DIV_MAX;
  assign core_op = state_q == S_SCAN ? idx_nx : Mode ? OP_AND : Op_Sel;
  gate_bitwise_core #(.WIDTH(WIDTH)) u_core (
    .op(core_op),
    .a(a_use),
    .b(b_use),
    .y(y),
    .illegal(illegal)
  );
  // Mode decisions, scan sequencing and result update
  always_comb begin
    state_d = state_q;
    a_d = a_use;
    b_d = b_use;
    idx_d = idx_q;
    div_d = div_q;
    res_d = res_q;
    vld_d = 1'b0;
    opc_d = opc_q;
    err_d = err_q;
    if (state_q != S_SCAN) begin
      if (Mode) begin
        state_d = S_SCAN;
        idx_d = OP_AND;
        div_d = '0;
        res_d = y;
        vld_d = 1'b1;
        opc_d = OP_AND;
        err_d = 1'b0;
      end else if (In_Valid) begin
        state_d = S_MAN;
        res_d = y;
        vld_d = 1'b1;
        opc_d = Op_Sel;
        err_d = illegal;
      end
    end else if (!Mode) begin
      state_d = S_MAN;
      div_d = '0;
    end else if (term) begin
      idx_d = idx_nx;
      div_d = '0;
      res_d = y;
      vld_d = 1'b1;
      opc_d = idx_nx;
    end else begin
      div_d = div_q + DW'(1);
    end
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      idx_q <= '0;
      div_q <= '0;
      res_q <= '0;
      vld_q <= 1'b0;
      opc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      idx_q <= idx_d;
      div_q <= div_d;
      res_q <= res_d;
      vld_q <= vld_d;
      opc_q <= opc_d;
      err_q <= err_d;
    end
  end
  assign Result = res_q;
  assign Out_Valid = vld_q;
  assign Op_Cur = opc_q;
  assign Op_Err = err_q;
`ifdef GATE_PARITY_EN
  logic par_q, par_d;
  assign par_d = ^res_d;
  // Parity is registered alongside Result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) par_q <= 1'b0;
    else par_q <= par_d;
  end
  assign Parity = par_q;
`endif
endmodule

// File: doc/gate_scan_unit.md
# gate_scan_unit

Registered, parametrised bitwise gate unit for the lab board's logic-gate demonstration path. It computes one of six two-operand gate functions (AND, NAND, OR, NOR, XOR, XNOR) on WIDTH-bit operands. It supports a manual mode, where each captured request produces one result, and a scan mode, where it steps through all six functions on the held operands at a fixed cycle interval. Results drive the LED/display stage downstream.

## Interface
- WIDTH, 4: operand and result width in bits (≥1).
- SCAN_DIV, 50_000_000: cycles per scan step (≥2).
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- A_In  in  WIDTH  operand A.
- B_In  in  WIDTH  operand B.
- Op_Sel  in  3  0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6/7 illegal.
- Mode  in  1  0 manual, 1 scan.
- In_Valid  in  1  capture strobe for A_In, B_In, Op_Sel.
- Result  out  WIDTH  registered gate result.
- Out_Valid  out  1  one-cycle pulse marking a new Result.
- Op_Cur  out  3  op encoding that produced Result.
- Op_Err  out  1  high while Result came from an illegal Op_Sel.

## Operation
- States: S_IDLE (after reset, no operands held), S_MAN, S_SCAN.
- S_IDLE:
  - In_Valid captures operands and Op_Sel.
  - Next state is S_MAN, or S_SCAN if Mode=1.
  - Mode=1 without In_Valid enters S_SCAN with zero operands.
- S_MAN:
  - Each In_Valid cycle captures A_In, B_In, Op_Sel.
  - Result = f(Op_Sel, A, B) is registered with a single Out_Valid pulse.
  - Illegal op: Result=0, Op_Err=1. Any legal capture clears Op_Err.
- S_MAN → S_SCAN when Mode rises:
  - Scan index set to 0, divider cleared.
  - Result for op 0 is produced with Out_Valid on the next cycle.
- S_SCAN:
  - Divider counts 0..SCAN_DIV-1.
  - On terminal count, index advances 0→1→…→5→0 (wrap), Result recomputes, Out_Valid pulses.
  - Op_Err=0 throughout. Op_Sel is ignored.
  - In_Valid updates operands only. Result refreshes at the next step; index and divider are unaffected.
  - Simultaneous In_Valid and terminal count: new operands and new index both apply, with one Out_Valid.
- S_SCAN → S_MAN when Mode falls:
  - Result and Op_Cur hold.
  - Divider is cleared.
  - No Out_Valid until the next In_Valid.
- Reset (any time, including mid-scan): Result=0, Out_Valid=0, Op_Cur=0, Op_Err=0, state S_IDLE, index 0, divider 0, operands 0.

## Timing
- Manual latency: In_Valid at edge n → Result/Out_Valid valid after edge n+1. Back-to-back In_Valid gives back-to-back results.
- Scan step period: exactly SCAN_DIV cycles between Out_Valid pulses. First pulse is 1 cycle after Mode rises.
- Reset acts without a clock edge. Release is synchronous to the CLK domain, with the first capture on the following edge.
- Divider width: $clog2(SCAN_DIV). Index is 3 bits; values 6/7 are never reached.

## Configuration
- GATE_PARITY_EN defined:
  - Adds output Parity (1 bit) = XOR-reduction of Result.
  - Registered in the same cycle as Result. Reset value 0.
- GATE_PARITY_EN undefined: the Parity port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package gate_pkg:
  - Op encodings OP_AND..OP_XNOR, plus OP_LAST=5.
  - State encoding S_IDLE/S_MAN/S_SCAN.
- Sub-module gate_bitwise_core: purely combinational (WIDTH, op, a, b → y, illegal).
- Top-level holds the state machine, divider, index and output registers.

## Test plan
All scenarios use WIDTH=4 and SCAN_DIV=4.
- Reset asserted mid-cycle → all outputs 0 immediately; after release, no Out_Valid without In_Valid.
- Manual, A=1100, B=1010:
  - Op 0 → 1000; 1 → 0111; 2 → 1110; 3 → 0001; 4 → 0110; 5 → 1001.
  - Each result appears 1 cycle after In_Valid with a single-cycle Out_Valid and matching Op_Cur.
- Manual, Op_Sel=7 → Result=0000, Op_Err=1; then Op_Sel=2 → Op_Err=0, Result=1110.
- Scan with A=1100, B=1010:
  - Sequence 1000, 0111, 1110, 0001, 0110, 1001, 1000 (wrap), with Out_Valid every 4 cycles.
  - In_Valid with B=0000 mid-scan → next step uses the new B (e.g. OR → 1100); no extra pulse.
- Async reset during scan step 3 → immediate clear, index 0; Mode held high restarts from op 0.
- With GATE_PARITY_EN: Result 0110 → Parity 0; Result 0111 → Parity 1, same cycle as Out_Valid.
